systolic_output_deskew: RTL
===========================

SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

Interface
- REQ-001: The block SHALL have parameter LANES, default 32, giving the number of systolic array columns (lanes).
- REQ-002: The block SHALL have parameter DW, default 32, giving the result data width per lane.
- REQ-003: The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-004: The block SHALL have port rst_n_i, input, 1 bit; reset is synchronous and active-low.
- REQ-005: The block SHALL have port start_i, input, 1 bit, a one-cycle request to begin collecting a tile.
- REQ-006: The block SHALL have port num_rows_i, input, 8 bits, rows in the tile; value 0 means 256.
- REQ-007: The block SHALL have port valid_i, input, 1 bit, marking that data_i[0] carries the head of a new result row this cycle.
- REQ-008: The block SHALL have port data_i, input, LANES x DW, skewed array outputs; lane j of a row arrives j cycles after lane 0.
- REQ-009: The block SHALL have port valid_o, output, 1 bit, marking that data_o holds one complete aligned row.
- REQ-010: The block SHALL have port data_o, output, LANES x DW, the deskewed row with all lanes aligned.
- REQ-011: The block SHALL have port row_idx_o, output, 8 bits, the index (0..N-1) of the row on data_o, valid with valid_o.
- REQ-012: The block SHALL have port busy_o, output, 1 bit, high in ACTIVE and DRAIN.
- REQ-013: The block SHALL have port done_o, output, 1 bit, a one-cycle pulse when the last row of the tile is on data_o.

Function
- REQ-014: Lane j SHALL be delayed by LANES-1-j register stages so that all lanes of a row align; lane LANES-1 gets no extra delay.
- REQ-015: For a head accepted in cycle t, data_o and valid_o SHALL present that row in cycle t+LANES (fixed latency LANES, one output register included).
- REQ-016: An accepted head SHALL be tracked by a LANES-deep valid token shift chain; data lanes SHALL shift every cycle regardless of valid.
- REQ-017: The FSM SHALL have states IDLE, ACTIVE and DRAIN.
- REQ-018: In IDLE, start_i SHALL latch num_rows_i (N), clear the accept and emit counters, and move to ACTIVE.
- REQ-019: A valid_i in the same cycle as the accepting start_i SHALL NOT be accepted.
- REQ-020: In ACTIVE, each valid_i SHALL be accepted and increment the accept count; on the Nth accept the FSM SHALL go to DRAIN.
- REQ-021: A valid_i in IDLE or DRAIN SHALL be ignored: no token, and no valid_o is ever generated for it.
- REQ-022: start_i in ACTIVE or DRAIN SHALL be ignored.
- REQ-023: row_idx_o SHALL equal the emit counter; the emit counter SHALL increment after each valid_o.
- REQ-024: done_o SHALL assert in the same cycle as the valid_o of row N-1, and the FSM SHALL return to IDLE on that edge.
- REQ-025: Back-to-back heads (valid_i every cycle) SHALL produce valid_o every cycle with no bubbles.
- REQ-026: Data SHALL pass unmodified at width DW; the block performs no arithmetic on data.
- REQ-027: When valid_o is 0, data_o SHALL hold the shifted values (don't-care); checkers SHALL ignore data_o while valid_o is 0.
- REQ-028: The block SHALL have no backpressure; the consumer SHALL accept every valid_o.

Reset
- REQ-029: While rst_n_i is 0 at a clock edge, the block SHALL set state to IDLE and clear all valid tokens and counters, with valid_o=0, done_o=0, busy_o=0, row_idx_o=0 and data_o=0.
- REQ-030: Reset mid-tile SHALL discard all in-flight rows; no valid_o SHALL appear after reset until a new start_i.
- REQ-031: Data pipeline registers SHALL reset to 0.

Verification
- REQ-032: Single row: start_i with N=1, then valid_i at t with lane j = 0x100+j at t+j -> valid_o=1 at t+32 with data_o[j]=0x100+j, row_idx_o=0, done_o=1, busy_o=0 from t+33.
- REQ-033: Streaming: N=4 with heads on 4 consecutive cycles, row r lane j = r*0x1000+j -> four consecutive valid_o with row_idx 0..3 and correct data, done_o with row 3 only.
- REQ-034: Ignored inputs: valid_i while IDLE, valid_i in the start_i cycle, and a 5th valid_i after N=4 -> exactly 4 valid_o; a second start_i during ACTIVE does not change N.
- REQ-035: N=0: start_i with num_rows_i=0 and 256 heads -> 256 valid_o with row_idx 0..255, done_o on row 255.
- REQ-036: Mid-tile reset: N=8, reset after 3 heads -> no valid_o afterwards and all outputs 0; a fresh N=2 tile then completes correctly.
- REQ-037: Gapped heads: N=3 with heads at t, t+5 and t+40 -> valid_o at t+32, t+37 and t+72 only.

Source files
------------

// File: rtl/systolic_output_deskew.sv
// Systolic output deskew: realigns the skewed per-lane results of a systolic
// array column set into complete rows and tags each row with its tile index.
// Lane j of a row arrives j cycles after lane 0. Each lane is delayed so that
// all lanes line up, and a row leaves the block LANES cycles after its head.
module systolic_output_deskew #(
  parameter int LANES = 32,
  parameter int DW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [7:0]                 num_rows_i,
  input  logic                       valid_i,
  input  logic [LANES-1:0][DW-1:0]   data_i,
  output logic                       valid_o,
  output logic [LANES-1:0][DW-1:0]   data_o,
  output logic [7:0]                 row_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } stateT;

  stateT                      r_state;
  logic [8:0]                 r_numRows;
  logic [8:0]                 r_acceptCnt;
  logic [7:0]                 r_emitCnt;
  logic                       r_done;
  logic                       r_busy;
  logic [LANES-1:0]           r_tokens;
  logic [LANES-1:0][DW-1:0]   r_dataOut;

  logic [LANES-1:0][DW-1:0]   w_aligned;
  logic                       w_accept;
  logic                       w_lastAccept;
  logic [8:0]                 w_emitNext;
  logic                       w_doneNext;

  // Heads are only taken while a tile is being collected; the start cycle
  // itself is still IDLE, so a head coinciding with start is dropped.
  assign w_accept     = (r_state == S_ACTIVE) && valid_i;
  assign w_lastAccept = w_accept && ((r_acceptCnt + 9'd1) == r_numRows);

  // Number of rows emitted once the row currently on data_o is counted; the
  // row being loaded into the output register next is the last one when this
  // equals N-1, which lets done_o be registered alongside valid_o.
  assign w_emitNext = {1'b0, r_emitCnt} + {8'd0, r_tokens[LANES-1]};
  assign w_doneNext = r_tokens[LANES-2] && (w_emitNext == (r_numRows - 9'd1));

  // Per-lane delay lines: lane j needs LANES-1-j stages so every lane of a
  // row reaches the output register in the same cycle. The last lane is
  // already the latest arrival and passes straight through.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam int DEPTH = LANES - 1 - j;
    if (DEPTH == 0) begin : g_pass
      assign w_aligned[j] = data_i[j];
    end else begin : g_delay
      logic [DW-1:0] r_stage [DEPTH];

      // Shift this lane's data every cycle, independent of any valid token.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_stage[k] <= '0;
          end
        end else begin
          r_stage[0] <= data_i[j];
          for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end

      assign w_aligned[j] = r_stage[DEPTH-1];
    end
  end

  // Output data register: captures the aligned row every cycle; its contents
  // only mean something while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_dataOut <= '0;
    end else begin
      r_dataOut <= w_aligned;
    end
  end

  // Valid token chain: an accepted head enters at the bottom and reaches the
  // top (which drives valid_o) exactly when its aligned row is on data_o.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_tokens <= '0;
    end else begin
      r_tokens <= {r_tokens[LANES-2:0], w_accept};
    end
  end

  // Tile control: latches the row count on start, counts accepted heads and
  // emitted rows, and returns to IDLE on the edge that retires the last row.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_numRows   <= '0;
      r_acceptCnt <= '0;
      r_emitCnt   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= w_doneNext;
      if (r_tokens[LANES-1]) begin
        r_emitCnt <= r_emitCnt + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_numRows   <= (num_rows_i == 8'd0) ? 9'd256 : {1'b0, num_rows_i};
            r_acceptCnt <= '0;
            r_emitCnt   <= '0;
            r_state     <= S_ACTIVE;
            r_busy      <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_accept) begin
            r_acceptCnt <= r_acceptCnt + 9'd1;
          end
          if (w_lastAccept) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o   = r_tokens[LANES-1];
  assign data_o    = r_dataOut;
  assign row_idx_o = r_emitCnt;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule
